// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared widths, reset pc, command and fetch-state encodings (CHIP8_STACK_ERR_EN selects stack error handling)
package fetch_unit_pkg;
  localparam int ADDR_W = 12;
  localparam logic [ADDR_W-1:0] DEF_START_ADDR = 12'h200;
  typedef enum logic [2:0] {OP_NEXT, OP_SKIP, OP_JUMP, OP_CALL, OP_RET} op_e;
  typedef enum logic [1:0] {RD_HI, RD_LO, CAP_LO, VALID} state_e;
endpackage

// File: rtl/chip8_ret_stack.sv
// chip8_ret_stack: synchronous return-address LIFO; CHIP8_STACK_ERR_EN adds overflow/underflow blocking with a sticky error
module chip8_ret_stack #(
  parameter int DEPTH = 16,
  parameter int SP_W  = 4,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [SP_W:0] count,
  output logic          err
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [SP_W:0] sp_q, sp_d;
  logic [SP_W-1:0] wr_idx, rd_idx;
  logic do_push, do_pop;
  assign wr_idx = sp_q[SP_W-1:0];
  assign rd_idx = wr_idx - SP_W'(1);
  assign dout = mem_q[rd_idx];
  assign count = sp_q;
`ifdef CHIP8_STACK_ERR_EN
  localparam logic [SP_W:0] FULL = (SP_W+1)'(DEPTH);
  logic err_q;
  assign do_push = push && sp_q != FULL;
  assign do_pop = pop && sp_q != '0;
  assign sp_d = do_push ? sp_q + (SP_W+1)'(1) : do_pop ? sp_q - (SP_W+1)'(1) : sp_q;
  assign err = err_q;
  // error is sticky until reset; set by any refused push or pop
  always_ff @(posedge clk)
    if (rst) err_q <= 1'b0;
    else if ((push && !do_push) || (pop && !do_pop)) err_q <= 1'b1;
`else
  assign do_push = push;
  assign do_pop = pop;
  assign sp_d = {1'b0, do_push ? wr_idx + SP_W'(1) : do_pop ? rd_idx : wr_idx};
  assign err = 1'b0;
`endif
  // stack pointer; reset empties the stack
  always_ff @(posedge clk)
    if (rst) sp_q <= '0;
    else sp_q <= sp_d;
  // entry storage needs no reset since occupancy gates meaningful reads
  always_ff @(posedge clk)
    if (!rst && do_push) mem_q[wr_idx] <= din;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: pc, two-byte instruction fetch FSM and command sequencing; CHIP8_STACK_ERR_EN makes RET on empty stack advance pc by 2
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] START_ADDR  = DEF_START_ADDR,
  parameter int                STACK_DEPTH = 16,
  parameter int                SP_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic [15:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] op_addr,
  output logic [SP_W:0]     sp_out,
  output logic              stack_err
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, pop_addr, ret_addr;
  logic [7:0] hi_q, lo_q;
  logic cmd, push, pop;
  assign cmd = state_q == VALID && op_valid && op <= OP_RET;
  assign push = cmd && op == OP_CALL;
  assign pop = cmd && op == OP_RET;
  assign instr_valid = state_q == VALID;
  assign instruction = {hi_q, lo_q};
  assign instr_pc = ipc_q;
  assign mem_rd = !rst && (state_q == RD_HI || state_q == RD_LO);
  assign mem_addr = rst ? '0 : state_q == RD_HI ? pc_q : state_q == RD_LO ? pc_q + ADDR_W'(1) : '0;
`ifdef CHIP8_STACK_ERR_EN
  assign ret_addr = sp_out == '0 ? pc_q + ADDR_W'(2) : pop_addr;
`else
  assign ret_addr = pop_addr;
`endif
  chip8_ret_stack #(.DEPTH(STACK_DEPTH), .SP_W(SP_W), .DW(ADDR_W)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_q + ADDR_W'(2)),
    .dout  (pop_addr),
    .count (sp_out),
    .err   (stack_err)
  );
  // fetch sequence advances unconditionally until VALID, which waits for a defined command
  always_comb begin
    state_d = state_q == RD_HI ? RD_LO : state_q == RD_LO ? CAP_LO : state_q == CAP_LO ? VALID : cmd ? RD_HI : VALID;
    pc_d = !cmd ? pc_q : op == OP_NEXT ? pc_q + ADDR_W'(2) : op == OP_SKIP ? pc_q + ADDR_W'(4) : op == OP_RET ? ret_addr : op_addr;
  end
  // state, pc and byte assembly; RAM data lands one cycle after each read strobe
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= RD_HI;
      pc_q <= START_ADDR;
      hi_q <= '0;
      lo_q <= '0;
      ipc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      if (state_q == RD_LO) hi_q <= mem_data;
      if (state_q == CAP_LO) begin
        lo_q <= mem_data;
        ipc_q <= pc_q;
      end
    end
endmodule
